// File: rtl/ram_delay_pkg.sv
// Shared constants and state encoding for the RAM-based sample delay line.
package ram_delay_pkg;

  localparam int RAM_DELAY_NBITS_DATA = 42;
  localparam int RAM_DELAY_NBITS_ADDR = 9;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } ram_delay_state_t;

endpackage

// File: rtl/ram_delay_mem.sv
// Single-clock RAM with registered read-before-write; read data holds when rd_en is low.
module ram_delay_mem
  import ram_delay_pkg::*;
#(
  parameter int P_NBITS_DATA = RAM_DELAY_NBITS_DATA,
  parameter int P_NBITS_ADDR = RAM_DELAY_NBITS_ADDR
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic                    rd_en,
  input  logic [P_NBITS_ADDR-1:0] addr,
  input  logic [P_NBITS_DATA-1:0] wdata,
  output logic [P_NBITS_DATA-1:0] rdata
);

  logic [P_NBITS_DATA-1:0] mem_reg [2**P_NBITS_ADDR];
  logic [P_NBITS_DATA-1:0] rdata_reg;

  // Read and write share the address; the read returns the pre-write contents.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rdata_reg <= mem_reg[addr];
    end
    if (we) begin
      mem_reg[addr] <= wdata;
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/ram_delay.sv
// Delay line: qn is the sample written n accepted writes before qo (n=0 means full depth).
// Define RAM_DELAY_EXT_ADDR_EN to let addr_en/addr override the internal write pointer.
module ram_delay
  import ram_delay_pkg::*;
#(
  parameter int P_NBITS_DATA = RAM_DELAY_NBITS_DATA,
  parameter int P_NBITS_ADDR = RAM_DELAY_NBITS_ADDR
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [P_NBITS_DATA-1:0] d,
  input  logic                    wr,
  input  logic [P_NBITS_ADDR-1:0] n,
  input  logic                    flush,
  input  logic                    addr_en,
  input  logic [P_NBITS_ADDR-1:0] addr,
  input  logic [P_NBITS_DATA-1:0] d_reset,
  output logic [P_NBITS_DATA-1:0] qo,
  output logic [P_NBITS_DATA-1:0] qn,
  output logic                    valid
);

  localparam logic [P_NBITS_ADDR-1:0] ADDR_ONE = 1;

  ram_delay_state_t        state_reg;
  logic [P_NBITS_ADDR-1:0] ptr_reg;
  logic [P_NBITS_ADDR-1:0] clr_addr_reg;
  logic [P_NBITS_DATA-1:0] qo_reg;
  logic                    valid_reg;
  logic                    qn_live_reg;

  logic [P_NBITS_ADDR-1:0] n_last;
  logic [P_NBITS_ADDR-1:0] active_addr;
  logic [P_NBITS_ADDR-1:0] mem_addr;
  logic [P_NBITS_DATA-1:0] mem_wdata;
  logic [P_NBITS_DATA-1:0] mem_rdata;
  logic                    mem_we;
  logic                    clearing;
  logic                    accept;

  // n=0 wraps n_last to all ones, so both the sweep and the pointer span the whole RAM.
  assign n_last   = n - ADDR_ONE;
  assign clearing = (state_reg == ST_CLEAR);
  assign accept   = wr && !clearing && !rst;

`ifdef RAM_DELAY_EXT_ADDR_EN
  assign active_addr = addr_en ? addr : ptr_reg;
`else
  logic unused_ext;
  assign unused_ext  = ^{addr_en, addr};
  assign active_addr = ptr_reg;
`endif

  assign mem_we    = !rst && (clearing || wr);
  assign mem_addr  = clearing ? clr_addr_reg : active_addr;
  assign mem_wdata = clearing ? d_reset : d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_CLEAR;
      ptr_reg      <= '0;
      clr_addr_reg <= '0;
      qo_reg       <= '0;
      valid_reg    <= 1'b0;
      qn_live_reg  <= 1'b0;
    end else begin
      valid_reg <= accept && !flush;
      if (clearing) begin
        clr_addr_reg <= clr_addr_reg + ADDR_ONE;
        if (clr_addr_reg == n_last) begin
          state_reg <= ST_RUN;
        end
      end
      if (accept) begin
        qo_reg      <= d;
        qn_live_reg <= 1'b1;
        // >= also pulls a pointer left beyond a newly shortened n back to 0.
        ptr_reg     <= (ptr_reg >= n_last) ? '0 : ptr_reg + ADDR_ONE;
      end
    end
  end

  ram_delay_mem #(
    .P_NBITS_DATA(P_NBITS_DATA),
    .P_NBITS_ADDR(P_NBITS_ADDR)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .rd_en(accept),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  // The RAM read register has no reset, so qn reads as zero until the first write after reset.
  assign qo    = qo_reg;
  assign qn    = qn_live_reg ? mem_rdata : '0;
  assign valid = valid_reg;

endmodule

// File: tb/tb_ram_delay.sv
// Directed bench for ram_delay with a history-based scoreboard of expected qo/qn/valid.
module tb_ram_delay;

  localparam int DW    = 42;
  localparam int AW    = 9;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr = 1'b0;
  logic          flush = 1'b0;
  logic          addr_en = 1'b0;
  logic [DW-1:0] d = '0;
  logic [DW-1:0] d_reset = '0;
  logic [AW-1:0] n = 9'd16;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] qo;
  logic [DW-1:0] qn;
  logic          valid;

  typedef struct packed {
    logic [DW-1:0] qo;
    logic [DW-1:0] qn;
    logic          valid;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] hist[$];
  int            checks = 0;
  int            failures = 0;
  int            sweep_left = 0;
  int            n_eff = 16;
  logic [DW-1:0] held_qo = '0;
  logic [DW-1:0] held_qn = '0;

  ram_delay dut (
    .clk    (clk),
    .rst    (rst),
    .d      (d),
    .wr     (wr),
    .n      (n),
    .flush  (flush),
    .addr_en(addr_en),
    .addr   (addr),
    .d_reset(d_reset),
    .qo     (qo),
    .qn     (qn),
    .valid  (valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic rst_pulse(input logic [AW-1:0] nv, input logic [DW-1:0] drv);
    @(negedge clk);
    rst = 1'b1; wr = 1'b0; flush = 1'b0; n = nv; d_reset = drv;
    @(posedge clk); #1;
    chk("reset_valid", {41'd0, valid}, '0);
    chk("reset_qo", qo, '0);
    chk("reset_qn", qn, '0);
    rst = 1'b0;
    n_eff = (nv == '0) ? DEPTH : int'(nv);
    sweep_left = n_eff;
    hist.delete();
    sb.delete();
    held_qo = '0;
    held_qn = '0;
  endtask

  task automatic step(input logic w, input logic f, input logic [DW-1:0] dv, input logic [AW-1:0] av);
    exp_t e;
    bit   acc;
    @(negedge clk);
    wr = w; flush = f; d = dv; addr = av;
    acc = w && (sweep_left == 0);
    if (sweep_left > 0) sweep_left--;
    if (acc) begin
      e.qo    = dv;
      e.qn    = (hist.size() >= n_eff) ? hist[hist.size() - n_eff] : d_reset;
      e.valid = !f;
      sb.push_back(e);
      hist.push_back(dv);
    end
    @(posedge clk); #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      held_qo = e.qo;
      held_qn = e.qn;
      chk("valid", {41'd0, valid}, {41'd0, e.valid});
      $display("write d=%h -> qo=%h qn=%h valid=%0b", dv, qo, qn, valid);
    end else begin
      chk("idle_valid", {41'd0, valid}, '0);
    end
    chk("qo", qo, held_qo);
    chk("qn", qn, held_qn);
  endtask

  initial begin
    logic [DW-1:0] k;
    k = '0;

    // Sweep restart: reset again partway through the clear
    rst_pulse(9'd16, 42'h123);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, '0);
    rst_pulse(9'd16, 42'h123);

    // wr held high for the whole sweep must be ignored
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 42'h3ff000 + DW'(i), '0);

    // 16 flushed writes then 20 contiguous valid writes
    for (int i = 0; i < 16; i++) begin step(1'b1, 1'b1, k, '0); k++; end
    for (int i = 0; i < 20; i++) begin step(1'b1, 1'b0, k, '0); k++; end

    // Bursts with 1-4 idle cycles between them
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 20; i++) begin step(1'b1, 1'b0, k, '0); k++; end
      for (int g = 0; g < int'($urandom_range(1, 4)); g++) step(1'b0, 1'b0, k, '0);
    end

    // Alternating wr; in the default build addr_en/addr must have no effect
`ifndef RAM_DELAY_EXT_ADDR_EN
    addr_en = 1'b1;
`endif
    for (int i = 0; i < 40; i++) begin
      step((i % 2) == 0, 1'b0, k, AW'($urandom));
      if ((i % 2) == 0) k++;
    end
    addr_en = 1'b0;

    // Fill value visible for the first n writes after a mid-stream reset
    rst_pulse(9'd16, 42'habcdef);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0, '0, '0);

    // Shortest delay
    rst_pulse(9'd1, 42'h7);
    step(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 42'h100 + DW'(i), '0);

    // n=0 means full-depth delay
    rst_pulse(9'd0, 42'h3c);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < DEPTH + 8; i++) step(1'b1, (i % 7) == 3, 42'h5000 + DW'(i), '0);

`ifdef RAM_DELAY_EXT_ADDR_EN
    // External addressing cycling 0..15 behaves like the internal pointer
    rst_pulse(9'd16, 42'h55);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, '0, '0);
    addr_en = 1'b1;
    for (int i = 0; i < 36; i++) step(1'b1, 1'b0, 42'h900 + DW'(i), AW'(i % 16));
    addr_en = 1'b0;
`endif

    step(1'b0, 1'b0, '0, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
